// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-locked round-robin arbiter, two AXI-stream
// sources onto one registered AXI-stream master, with packet counters.
module axis_rr_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data_1,
  input  logic              s_valid_1,
  output logic              s_ready_1,
  input  logic              s_last_1,
  input  logic [DATA_W-1:0] s_data_2,
  input  logic              s_valid_2,
  output logic              s_ready_2,
  input  logic              s_last_2,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  pkt_cnt_1,
  output logic [CNT_W-1:0]  pkt_cnt_2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G1   = 2'd1,
    G2   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // high when src2 owned the last finished packet
  logic last2_q, last2_d;

  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic m_valid_q, m_valid_d;
  logic m_last_q, m_last_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;

  logic acc;
  logic hs1;
  logic hs2;

  // handshake terms: output slot free or draining this cycle
  always_comb begin
    acc       = !m_valid_q || m_ready;
    s_ready_1 = (state_q == G1) && acc;
    s_ready_2 = (state_q == G2) && acc;
    hs1       = s_valid_1 && s_ready_1;
    hs2       = s_valid_2 && s_ready_2;
    grant     = {state_q == G2, state_q == G1};
    m_data    = m_data_q;
    m_valid   = m_valid_q;
    m_last    = m_last_q;
    pkt_cnt_1 = cnt1_q;
    pkt_cnt_2 = cnt2_q;
  end

  // arbitration, packet lock and completed-packet counting
  always_comb begin
    state_d = state_q;
    last2_d = last2_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    unique case (state_q)
      IDLE: begin
        if (s_valid_1 && (!s_valid_2 || last2_q)) begin
          state_d = G1;
        end else if (s_valid_2) begin
          state_d = G2;
        end
      end
      G1: begin
        if (hs1 && s_last_1) begin
          state_d = IDLE;
          last2_d = 1'b0;
          cnt1_d  = cnt1_q + CNT_W'(1);
        end
      end
      G2: begin
        if (hs2 && s_last_2) begin
          state_d = IDLE;
          last2_d = 1'b1;
          cnt2_d  = cnt2_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // output register: load on handshake, drain on m_ready, else hold
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    if (hs1) begin
      m_data_d  = s_data_1;
      m_last_d  = s_last_1;
      m_valid_d = 1'b1;
    end else if (hs2) begin
      m_data_d  = s_data_2;
      m_last_d  = s_last_2;
      m_valid_d = 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      last2_q   <= 1'b1;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
    end else begin
      state_q   <= state_d;
      last2_q   <= last2_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: scoreboard bench with a cycle-level reference
// model of the arbitration rules and a decoupled output monitor.
module tb_axis_rr_arbiter;

  localparam int DW = 8;
  localparam int CW = 2;
  localparam int CMOD = 1 << CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic [DW-1:0] s_data_1 = '0, s_data_2 = '0;
  logic s_valid_1 = 1'b0, s_valid_2 = 1'b0;
  logic s_last_1 = 1'b0, s_last_2 = 1'b0;
  logic s_ready_1, s_ready_2;
  logic [DW-1:0] m_data;
  logic m_valid, m_last;
  logic m_ready = 1'b0;
  logic [1:0] grant;
  logic [CW-1:0] pkt_cnt_1, pkt_cnt_2;

  axis_rr_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .s_data_1(s_data_1), .s_valid_1(s_valid_1),
    .s_ready_1(s_ready_1), .s_last_1(s_last_1),
    .s_data_2(s_data_2), .s_valid_2(s_valid_2),
    .s_ready_2(s_ready_2), .s_last_2(s_last_2),
    .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last),
    .grant(grant),
    .pkt_cnt_1(pkt_cnt_1), .pkt_cnt_2(pkt_cnt_2)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic l;
    logic [1:0] src;
  } beat_t;

  beat_t sq1[$], sq2[$], exp_q[$];
  int ord_q[$];

  int checks = 0;
  int failures = 0;
  int pv = 100;
  int pr = 100;
  logic rst_drv = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // reference model: owner, previous winner, output occupancy, counts
  int m_own = 0;
  int m_prev = 2;
  bit m_mv = 0;
  int m_c1 = 0;
  int m_c2 = 0;
  bit model_on = 0;

  initial forever begin
    bit a, r1, r2, h1, h2;
    logic [1:0] g;
    @(negedge clk);
    if (!reset) begin
      model_on = 1;
      m_own = 0;
      m_prev = 2;
      m_mv = 0;
      m_c1 = 0;
      m_c2 = 0;
      exp_q.delete();
    end else if (model_on) begin
      g = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
      a = !m_mv || m_ready;
      r1 = (m_own == 1) && a;
      r2 = (m_own == 2) && a;
      chk("grant", grant, g);
      chk("s_ready_1", s_ready_1, r1);
      chk("s_ready_2", s_ready_2, r2);
      chk("m_valid", m_valid, m_mv);
      chk("pkt_cnt_1", pkt_cnt_1, m_c1);
      chk("pkt_cnt_2", pkt_cnt_2, m_c2);
      h1 = r1 && s_valid_1;
      h2 = r2 && s_valid_2;
      if (h1) begin
        exp_q.push_back({s_data_1, s_last_1, 2'd1});
        m_mv = 1;
      end else if (h2) begin
        exp_q.push_back({s_data_2, s_last_2, 2'd2});
        m_mv = 1;
      end else if (m_ready) begin
        m_mv = 0;
      end
      if (m_own == 0) begin
        if (s_valid_1 && (!s_valid_2 || m_prev == 2)) m_own = 1;
        else if (s_valid_2) m_own = 2;
      end else if (m_own == 1 && h1 && s_last_1) begin
        m_own = 0;
        m_prev = 1;
        m_c1 = (m_c1 + 1) % CMOD;
      end else if (m_own == 2 && h2 && s_last_2) begin
        m_own = 0;
        m_prev = 2;
        m_c2 = (m_c2 + 1) % CMOD;
      end
    end
  end

  // monitor: pop and compare each accepted output beat, check stalls
  initial begin
    bit stall;
    logic [DW-1:0] sd;
    logic sl;
    beat_t e;
    stall = 0;
    sd = '0;
    sl = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall = 0;
      end else begin
        if (stall) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, sd);
          chk("stall_last", m_last, sl);
        end
        if (m_valid && m_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL beat_unexpected actual=%0h expected=none",
                     m_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_data, e.d);
            chk("beat_last", m_last, e.l);
            if (e.l) ord_q.push_back(int'(e.src));
          end
        end
        stall = m_valid && !m_ready;
        sd = m_data;
        sl = m_last;
      end
    end
  end

  task automatic cycle();
    bit h1, h2;
    @(negedge clk);
    h1 = s_valid_1 && s_ready_1 && reset;
    h2 = s_valid_2 && s_ready_2 && reset;
    @(posedge clk);
    #1;
    if (h1) void'(sq1.pop_front());
    if (h2) void'(sq2.pop_front());
    if (!(s_valid_1 && !h1)) begin
      if (sq1.size() > 0 && $urandom_range(99) < pv) begin
        s_valid_1 = 1'b1;
        s_data_1 = sq1[0].d;
        s_last_1 = sq1[0].l;
      end else begin
        s_valid_1 = 1'b0;
        s_data_1 = DW'($urandom);
        s_last_1 = 1'($urandom);
      end
    end
    if (!(s_valid_2 && !h2)) begin
      if (sq2.size() > 0 && $urandom_range(99) < pv) begin
        s_valid_2 = 1'b1;
        s_data_2 = sq2[0].d;
        s_last_2 = sq2[0].l;
      end else begin
        s_valid_2 = 1'b0;
        s_data_2 = DW'($urandom);
        s_last_2 = 1'($urandom);
      end
    end
    reset = rst_drv;
    m_ready = rst_drv ? ($urandom_range(99) < pr) : 1'b0;
  endtask

  task automatic do_reset();
    rst_drv = 1'b0;
    cycle();
    rst_drv = 1'b1;
    cycle();
    ord_q.delete();
  endtask

  task automatic add_pkt(input int src, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = DW'($urandom);
      b.l = (i == len - 1);
      b.src = 2'(src);
      if (src == 1) sq1.push_back(b);
      else sq2.push_back(b);
    end
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((sq1.size() > 0 || sq2.size() > 0 || exp_q.size() > 0
            || m_valid) && n < lim) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= lim) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d expected<%0d", n, lim);
    end
  endtask

  initial begin
    beat_t b;
    int exp_ord[4];
    exp_ord = '{1, 2, 1, 2};

    do_reset();
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_grant", grant, 0);

    // single 3-beat src1 packet AA BB CC
    pv = 100;
    pr = 100;
    b.src = 2'd1;
    b.d = 8'hAA; b.l = 1'b0; sq1.push_back(b);
    b.d = 8'hBB; b.l = 1'b0; sq1.push_back(b);
    b.d = 8'hCC; b.l = 1'b1; sq1.push_back(b);
    drain(50);
    chk("p1_cnt1", pkt_cnt_1, 1);
    chk("p1_pkts", ord_q.size(), 1);

    // both sources busy: alternation src1,src2,src1,src2
    do_reset();
    add_pkt(1, 2); add_pkt(1, 2);
    add_pkt(2, 3); add_pkt(2, 3);
    drain(100);
    chk("p2_cnt1", pkt_cnt_1, 2);
    chk("p2_cnt2", pkt_cnt_2, 2);
    chk("p2_pkts", ord_q.size(), 4);
    for (int i = 0; i < 4 && i < ord_q.size(); i++)
      chk("p2_order", ord_q[i], exp_ord[i]);

    // five single-beat src1 packets wrap the 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) add_pkt(1, 1);
    drain(100);
    chk("p3_cnt1_wrap", pkt_cnt_1, 1);

    // random traffic with backpressure and a reset mid-stream
    do_reset();
    for (int i = 0; i < 40; i++) begin
      add_pkt(1, $urandom_range(4, 1));
      add_pkt(2, $urandom_range(4, 1));
    end
    pv = 70;
    pr = 60;
    repeat (250) cycle();
    do_reset();
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_cnt1", pkt_cnt_1, 0);
    drain(20000);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
Packet-aware round-robin arbiter that shares one AXI-stream master port between two AXI-stream slave sources. It replaces manual sel-driven switching in the stream mux path. Once a packet is granted it stays locked until that source's s_last beat is accepted. Output is registered, one stage, for timing isolation. Per-source completed-packet counters are exposed for debug.

Parameters:
DATA_W, 8, width of s_data_1, s_data_2 and m_data
CNT_W, 8, width of each completed-packet counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
s_data_1  input  DATA_W  source 1 data
s_valid_1  input  1  source 1 valid
s_ready_1  output  1  source 1 ready
s_last_1  input  1  source 1 end-of-packet marker
s_data_2  input  DATA_W  source 2 data
s_valid_2  input  1  source 2 valid
s_ready_2  output  1  source 2 ready
s_last_2  input  1  source 2 end-of-packet marker
m_data  output  DATA_W  registered output data
m_valid  output  1  registered output valid
m_ready  input  1  downstream ready
m_last  output  1  registered end-of-packet marker
grant  output  2  one-hot current owner: 01 = src1, 10 = src2, 00 = idle
pkt_cnt_1  output  CNT_W  packets from src1 fully accepted (last beat into output register)
pkt_cnt_2  output  CNT_W  packets from src2 fully accepted

Behaviour:
- Reset (reset=0 at a rising edge):
  - m_valid=0, m_last=0, m_data=0, grant=00.
  - pkt_cnt_1=0, pkt_cnt_2=0.
  - last-owner register = src2, so src1 wins the first tie.
  - FSM goes to IDLE.
- Reset mid-packet: any beat held in the output register is discarded. No partial state survives.
- FSM states:
  - IDLE: s_ready_1=s_ready_2=0; grant=00.
  - G1: s_ready_1=acc, s_ready_2=0; grant=01.
  - G2: s_ready_2=acc, s_ready_1=0; grant=10.
- Output-register accept term: acc = (!m_valid || m_ready), combinational. s_ready_x is combinational from state, m_valid and m_ready.
- IDLE arbitration (decision registered, takes effect next cycle):
  - Only s_valid_1: go G1.
  - Only s_valid_2: go G2.
  - Both valid: go to the source that is not the last owner.
  - Neither valid: stay IDLE.
  - s_last and s_data are ignored in IDLE.
- Lock: in Gx, state changes only when s_valid_x && s_ready_x && s_last_x (last-beat handshake). That cycle:
  - next state = IDLE;
  - last-owner = x;
  - pkt_cnt_x increments (wrapping).
- Packet gap: exactly one IDLE bubble cycle follows every packet, even if the other source is waiting.
- Output register:
  - Loads s_data_x and s_last_x with m_valid=1 on every slave handshake.
  - Clears m_valid when m_ready=1 and no new beat is loaded.
  - Holds data, last and valid stable while m_valid && !m_ready (AXI-stream compliant).
- Throughput: with m_ready held 1 and the owner's s_valid held 1, one beat per cycle.
- Latency: slave handshake to m_valid is 1 cycle.
- The non-granted source's valid and last are ignored. Its s_ready stays 0, so no beats are dropped or duplicated.
- A single-beat packet (s_last on the first beat) is legal: Gx lasts one handshake cycle.
- A source deasserting s_valid mid-packet is legal: the lock holds, and the arbiter waits indefinitely for s_last_x.
- Counter wrap: pkt_cnt_x = 2^CNT_W-1, then +1, gives 0. No saturation, no flag.

Test Plan:
- Reset then src1-only 3-beat packet (AA,BB,CC; last on CC), m_ready=1 -> cycle 1 grant=01; m_data AA,BB,CC on consecutive cycles; m_last=1 only with CC; pkt_cnt_1=1; grant=00 the cycle after the CC handshake.
- Both sources valid from reset, src1 packets of 2 beats, src2 packets of 3 beats, m_ready=1 -> order src1,src2,src1,src2 with one idle cycle between packets; pkt_cnt_1=pkt_cnt_2=2 after 4 packets.
- src1 packet with m_ready toggling 0,1,0,0,1,1 -> m_data, m_last and m_valid stable while stalled; s_ready_1=0 whenever m_valid=1 and m_ready=0; no beat lost or duplicated against a scoreboard.
- src2 granted mid-packet with s_valid_1 asserted and s_last_1 pulsed -> s_ready_1 stays 0, no src1 data on m_data, pkt_cnt_1 unchanged until src2 s_last handshake completes.
- Drive reset=0 for one cycle mid-packet with m_valid=1 -> next cycle m_valid=0, grant=00, counters 0; next arbitration with both valid grants src1.
- CNT_W=2, 5 single-beat src1 packets -> pkt_cnt_1 sequence 1,2,3,0,1.
